// File: rtl/pipe_stage_skid.sv
// Pipeline stage boundary with valid/ready handshake and a two-entry skid buffer.
// It also provides a synchronous flush that leaves a bubble, and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W = 160,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] skid;
  logic              in_fire;
  logic              out_fire;

  // Every output is a decode of registered state, so there is no input-to-output path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign occupancy = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= EMPTY;
      head  <= BUBBLE;
      skid  <= BUBBLE;
    end else if (flush) begin
      state <= EMPTY;
      head  <= BUBBLE;
      skid  <= BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head <= in_data;
          end else if (in_fire) begin
            skid  <= in_data;
            state <= FULL;
          end else if (out_fire) begin
            head  <= BUBBLE;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            head  <= skid;
            skid  <= BUBBLE;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          head  <= BUBBLE;
          skid  <= BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
